// File: rtl/sdram_port_arb.sv
// Two-client arbiter (Oric CPU, DMA write port) onto a toggle req/ack SDRAM port.
// Optional access timeout and sticky err flag are built only when SDRAM_ARB_TIMEOUT_EN is defined.
module sdram_port_arb #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        cpu_cs,
   input  logic        cpu_oe,
   input  logic        cpu_we,
   input  logic [15:0] cpu_ad,
   input  logic [7:0]  cpu_d,
   output logic [7:0]  cpu_q,
   input  logic        dma_wr,
   input  logic [15:0] dma_ad,
   input  logic [7:0]  dma_d,
   output logic        dma_busy,
   output logic        sd_req,
   input  logic        sd_ack,
   output logic        sd_we,
   output logic [1:0]  sd_ds,
   output logic [15:0] sd_a,
   output logic [15:0] sd_d,
   input  logic [15:0] sd_q,
   output logic        err,
   output logic [1:0]  fsm_state
);

   // The wait counter is 8 bits wide, so only 1..255 is meaningful.
   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("sdram_port_arb: TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_WAIT = 2'd1,
      DMA_WAIT = 2'd2
   } state_t;

   state_t      state, state_nx;

   logic        cpu_rd, cpu_wr, prev_rd, prev_wr, armed, cpu_det;
   logic [15:0] prev_ad;
   logic        cpu_pend, cpu_pwe;
   logic [15:0] cpu_pa;
   logic [7:0]  cpu_pd;
   logic        dma_pend;
   logic [15:0] dma_pa;
   logic [7:0]  dma_pd;
   logic        sync, issue_cpu, issue_dma, done, tmo, dma_done, dma_accept;
   logic        iss_we;
   logic [15:0] iss_a;
   logic [7:0]  iss_d;

   assign cpu_rd = cpu_cs & cpu_oe;
   assign cpu_wr = cpu_cs & cpu_we;
   // armed masks the first cycle after reset so levels already high then are not seen as edges.
   assign cpu_det = armed & ((cpu_rd & ~prev_rd) | (cpu_wr & ~prev_wr) |
                             (cpu_rd & (cpu_ad != prev_ad)));

   assign sync       = (sd_ack == sd_req);
   assign dma_done   = done & (state == DMA_WAIT);
   assign dma_accept = dma_wr & (~dma_busy | dma_done);
   assign fsm_state  = state;

   always_comb begin
      state_nx  = state;
      issue_cpu = 1'b0;
      issue_dma = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (sync && cpu_pend) begin
               issue_cpu = 1'b1;
               state_nx  = CPU_WAIT;
            end else if (sync && dma_pend) begin
               issue_dma = 1'b1;
               state_nx  = DMA_WAIT;
            end
         end
         CPU_WAIT, DMA_WAIT: begin
            if (sync) begin
               done     = 1'b1;
               state_nx = IDLE;
            end else if (tmo) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      iss_we = 1'b1;
      iss_a  = dma_pa;
      iss_d  = dma_pd;
      if (issue_cpu) begin
         iss_we = cpu_pwe;
         iss_a  = cpu_pa;
         iss_d  = cpu_pd;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         armed    <= 1'b0;
         prev_rd  <= 1'b0;
         prev_wr  <= 1'b0;
         prev_ad  <= 16'h0000;
         cpu_pend <= 1'b0;
         cpu_pwe  <= 1'b0;
         cpu_pa   <= 16'h0000;
         cpu_pd   <= 8'h00;
         dma_pend <= 1'b0;
         dma_pa   <= 16'h0000;
         dma_pd   <= 8'h00;
         dma_busy <= 1'b0;
         sd_req   <= 1'b0;
         sd_we    <= 1'b0;
         sd_ds    <= 2'b11;
         sd_a     <= 16'h0000;
         sd_d     <= 16'h0000;
         cpu_q    <= 8'h00;
      end else begin
         armed   <= 1'b1;
         prev_rd <= cpu_rd;
         prev_wr <= cpu_wr;
         prev_ad <= cpu_ad;

         // A fresh detection wins over clearing on issue: the newer request must not be lost.
         if (cpu_det) begin
            cpu_pend <= 1'b1;
            cpu_pa   <= cpu_ad;
            cpu_pd   <= cpu_d;
            cpu_pwe  <= cpu_wr;
         end else if (issue_cpu) begin
            cpu_pend <= 1'b0;
         end

         if (dma_accept) begin
            dma_pend <= 1'b1;
            dma_pa   <= dma_ad;
            dma_pd   <= dma_d;
         end else if (issue_dma) begin
            dma_pend <= 1'b0;
         end

         if (dma_accept)
            dma_busy <= 1'b1;
         else if (state == DMA_WAIT && (done || tmo))
            dma_busy <= 1'b0;

         if (issue_cpu || issue_dma) begin
            sd_req <= ~sd_req;
            sd_we  <= iss_we;
            sd_a   <= iss_a;
            sd_d   <= {iss_d, iss_d};
            sd_ds  <= iss_we ? (iss_a[0] ? 2'b10 : 2'b01) : 2'b11;
         end else if (tmo) begin
            sd_req <= sd_ack;
         end

         if (done && state == CPU_WAIT && !sd_we)
            cpu_q <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
      end
   end

`ifdef SDRAM_ARB_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   logic [7:0] wait_cnt;

   assign tmo = (state != IDLE) && !sync && (wait_cnt == TO_LAST);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= 8'd0;
         err      <= 1'b0;
      end else begin
         if (state == IDLE) wait_cnt <= 8'd0;
         else               wait_cnt <= wait_cnt + 8'd1;
         if (tmo) err <= 1'b1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: vector table of CPU accesses plus hand sequences for
// arbitration, DMA drop/re-accept, timeout (or indefinite wait) and reset corners.
module tb_sdram_port_arb;
   localparam int W = 35;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        cpu_cs, cpu_oe, cpu_we;
   logic [15:0] cpu_ad;
   logic [7:0]  cpu_d;
   logic [7:0]  cpu_q;
   logic        dma_wr;
   logic [15:0] dma_ad;
   logic [7:0]  dma_d;
   logic        dma_busy;
   logic        sd_req, sd_ack, sd_we, err;
   logic [1:0]  sd_ds, fsm_state;
   logic [15:0] sd_a, sd_d, sd_q;

   sdram_port_arb #(.TIMEOUT(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_ad(cpu_ad),
      .cpu_d(cpu_d), .cpu_q(cpu_q),
      .dma_wr(dma_wr), .dma_ad(dma_ad), .dma_d(dma_d), .dma_busy(dma_busy),
      .sd_req(sd_req), .sd_ack(sd_ack), .sd_we(sd_we), .sd_ds(sd_ds),
      .sd_a(sd_a), .sd_d(sd_d), .sd_q(sd_q), .err(err), .fsm_state(fsm_state)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic        we;
      logic [15:0] a;
      logic [7:0]  d;
      logic [15:0] q;
      int          dly;
      logic [1:0]  exp_ds;
      logic [7:0]  exp_cpu_q;
   } vec_t;

   vec_t        vecs[6];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_issue  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_exp;
   logic        cur_valid;
   logic        last_req;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rec(input logic we, input logic [15:0] a,
                                        input logic [7:0] d, input logic [1:0] ds);
      return {we, a, d, d, ds};
   endfunction

   // Scoreboard: each request toggle pops one expected access; held outputs checked while waiting.
   initial begin
      last_req  = 1'b0;
      cur_valid = 1'b0;
      forever begin
         @(posedge clk_sys);
         #1;
         if (!reset_n) begin
            last_req  = sd_req;
            cur_valid = 1'b0;
         end else begin
            if (sd_req != last_req) begin
               last_req = sd_req;
               if (sd_req != sd_ack) begin
                  n_issue++;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_issue: actual a=%h we=%b, required no request", sd_a, sd_we);
                     cur_valid = 1'b0;
                  end else begin
                     cur_exp   = exp_q.pop_front();
                     cur_valid = 1'b1;
                     check("issue", {sd_we, sd_a, sd_d, sd_ds}, cur_exp);
                  end
               end else begin
                  cur_valid = 1'b0;
               end
            end else if (cur_valid && fsm_state != 2'd0) begin
               check("hold", {sd_we, sd_a, sd_d, sd_ds}, cur_exp);
            end
            if (fsm_state == 2'd0) cur_valid = 1'b0;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic serve(input int dly, input logic [15:0] q);
      int n = 0;
      while (sd_req == sd_ack && n < 20) begin
         @(negedge clk_sys);
         n++;
      end
      if (sd_req == sd_ack) begin
         n_checks++;
         n_fail++;
         $display("FAIL serve_wait: actual no request in 20 cycles, required a request toggle");
      end else begin
         repeat (dly - 1) @(negedge clk_sys);
         sd_q   = q;
         sd_ack = ~sd_ack;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk_sys);
      while (fsm_state != 2'd0 && n < 300) begin
         @(negedge clk_sys);
         n++;
      end
      if (fsm_state != 2'd0) begin
         n_checks++;
         n_fail++;
         $display("FAIL idle_wait: actual state %0d, required 0 within 300 cycles", fsm_state);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual time limit reached, required test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      vecs[0] = '{1'b0, 16'h1235, 8'h00, 16'hAB12, 3, 2'b11, 8'hAB};
      vecs[1] = '{1'b1, 16'h0400, 8'h5A, 16'h0000, 2, 2'b01, 8'hAB};
      vecs[2] = '{1'b0, 16'h0400, 8'h00, 16'h34CD, 1, 2'b11, 8'hCD};
      vecs[3] = '{1'b1, 16'h0401, 8'hC3, 16'hFFFF, 4, 2'b10, 8'hCD};
      vecs[4] = '{1'b0, 16'hFFFF, 8'h11, 16'h7E00, 5, 2'b11, 8'h7E};
      vecs[5] = '{1'b0, 16'h0000, 8'h22, 16'h0099, 2, 2'b11, 8'h99};

      reset_n = 1'b0;
      cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0; cpu_ad = 16'h0000; cpu_d = 8'h00;
      dma_wr = 1'b0; dma_ad = 16'h0000; dma_d = 8'h00;
      sd_ack = 1'b0; sd_q = 16'h0000;
      tick(2);
      check("rst_sd_req", sd_req, 1'b0);
      check("rst_sd_ds", sd_ds, 2'b11);
      check("rst_cpu_q", cpu_q, 8'h00);
      check("rst_dma_busy", dma_busy, 1'b0);
      check("rst_err", err, 1'b0);
      reset_n = 1'b1;
      tick(2);

      // Table of single CPU accesses.
      for (int i = 0; i < 6; i++) begin
         base   = n_issue;
         cpu_cs = 1'b1;
         cpu_ad = vecs[i].a;
         cpu_d  = vecs[i].d;
         if (vecs[i].we) cpu_we = 1'b1;
         else            cpu_oe = 1'b1;
         exp_q.push_back(rec(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].exp_ds));
         serve(vecs[i].dly, vecs[i].q);
         wait_idle();
         check("vec_cpu_q", cpu_q, vecs[i].exp_cpu_q);
         check("vec_one_toggle", n_issue - base, 1);
         cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
         tick(2);
      end

      // Address change while cs&oe held retriggers a read.
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h2000; cpu_d = 8'h00;
      exp_q.push_back(rec(1'b0, 16'h2000, 8'h00, 2'b11));
      serve(2, 16'h1122);
      wait_idle();
      check("addr_chg_q0", cpu_q, 8'h22);
      cpu_ad = 16'h2001;
      exp_q.push_back(rec(1'b0, 16'h2001, 8'h00, 2'b11));
      serve(2, 16'h5566);
      wait_idle();
      check("addr_chg_q1", cpu_q, 8'h55);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);

      // CPU and DMA in the same cycle: CPU first, DMA right after CPU completion.
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h3000;
      dma_wr = 1'b1; dma_ad = 16'h8001; dma_d = 8'h77;
      exp_q.push_back(rec(1'b0, 16'h3000, 8'h00, 2'b11));
      exp_q.push_back(rec(1'b1, 16'h8001, 8'h77, 2'b10));
      tick(1);
      dma_wr = 1'b0;
      check("tie_busy_accept", dma_busy, 1'b1);
      serve(2, 16'h00EE);
      wait_idle();
      check("tie_cpu_q", cpu_q, 8'hEE);
      check("tie_busy_mid", dma_busy, 1'b1);
      tick(1);
      check("tie_dma_issued", fsm_state, 2'd2);
      check("tie_busy_dma", dma_busy, 1'b1);
      serve(1, 16'h0000);
      wait_idle();
      check("tie_busy_clear", dma_busy, 1'b0);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);

      // Second dma_wr while busy is dropped.
      base   = n_issue;
      dma_wr = 1'b1; dma_ad = 16'h9000; dma_d = 8'h3C;
      exp_q.push_back(rec(1'b1, 16'h9000, 8'h3C, 2'b01));
      tick(1);
      dma_wr = 1'b0;
      tick(1);
      dma_wr = 1'b1; dma_ad = 16'h9002; dma_d = 8'h4D;
      tick(1);
      dma_wr = 1'b0;
      serve(1, 16'h0000);
      wait_idle();
      tick(3);
      check("drop_one_toggle", n_issue - base, 1);
      check("drop_busy_clear", dma_busy, 1'b0);

      // dma_wr on the DMA completion cycle is accepted.
      dma_wr = 1'b1; dma_ad = 16'h8100; dma_d = 8'h01;
      exp_q.push_back(rec(1'b1, 16'h8100, 8'h01, 2'b01));
      exp_q.push_back(rec(1'b1, 16'h8103, 8'h02, 2'b10));
      tick(1);
      dma_wr = 1'b0;
      tick(1);
      check("reacc_issued", fsm_state, 2'd2);
      sd_ack = ~sd_ack;
      dma_wr = 1'b1; dma_ad = 16'h8103; dma_d = 8'h02;
      tick(1);
      dma_wr = 1'b0;
      check("reacc_busy", dma_busy, 1'b1);
      check("reacc_idle", fsm_state, 2'd0);
      serve(1, 16'h0000);
      wait_idle();
      check("reacc_busy_clear", dma_busy, 1'b0);
      tick(2);

      // Access whose acknowledge never arrives.
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h4444;
      exp_q.push_back(rec(1'b0, 16'h4444, 8'h00, 2'b11));
      tick(2);
      check("to_issued", sd_req != sd_ack, 1'b1);
`ifdef SDRAM_ARB_TIMEOUT_EN
      tick(7);
      check("to_still_wait", fsm_state, 2'd1);
      check("to_err_early", err, 1'b0);
      tick(1);
      check("to_idle", fsm_state, 2'd0);
      check("to_err", err, 1'b1);
      check("to_resync", sd_req == sd_ack, 1'b1);
      check("to_cpu_q_hold", cpu_q, 8'h55 & 8'h00 | 8'hEE);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h4446;
      exp_q.push_back(rec(1'b0, 16'h4446, 8'h00, 2'b11));
      serve(1, 16'h2211);
      wait_idle();
      check("to_after_q", cpu_q, 8'h11);
      check("to_err_sticky", err, 1'b1);
`else
      tick(30);
      check("nto_still_wait", fsm_state, 2'd1);
      check("nto_err", err, 1'b0);
      serve(1, 16'h4321);
      wait_idle();
      check("nto_cpu_q", cpu_q, 8'h21);
`endif
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);

      // Reset in the middle of CPU_WAIT, then resynchronisation.
      cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h5555;
      exp_q.push_back(rec(1'b0, 16'h5555, 8'h00, 2'b11));
      tick(2);
      check("mid_cpu_wait", fsm_state, 2'd1);
      reset_n = 1'b0;
      #1;
      check("mr_state", fsm_state, 2'd0);
      check("mr_sd_req", sd_req, 1'b0);
      check("mr_sd_a", sd_a, 16'h0000);
      check("mr_sd_d", sd_d, 16'h0000);
      check("mr_sd_ds", sd_ds, 2'b11);
      check("mr_sd_we", sd_we, 1'b0);
      check("mr_err", err, 1'b0);
      check("mr_dma_busy", dma_busy, 1'b0);
      check("mr_cpu_q", cpu_q, 8'h00);
      sd_ack = 1'b1;
      tick(1);
      reset_n = 1'b1;
      tick(1);
      cpu_ad = 16'h5556;
      exp_q.push_back(rec(1'b0, 16'h5556, 8'h00, 2'b11));
      tick(4);
      check("desync_no_req", sd_req, 1'b0);
      check("desync_idle", fsm_state, 2'd0);
      sd_ack = 1'b0;
      serve(2, 16'hBEEF);
      wait_idle();
      check("resync_cpu_q", cpu_q, 8'hEF);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);

      // Levels already high at reset release are not requests.
      base    = n_issue;
      reset_n = 1'b0;
      sd_ack  = 1'b0;
      cpu_cs  = 1'b1; cpu_oe = 1'b1; cpu_ad = 16'h6000;
      tick(1);
      reset_n = 1'b1;
      tick(5);
      check("first_cycle_no_req", n_issue - base, 0);
      check("first_cycle_idle", fsm_state, 2'd0);
      cpu_cs = 1'b0; cpu_oe = 1'b0;
      tick(2);

      check("sb_drain", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/sdram_port_arb.md
SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning clk_sys cycles to wait for sd_ack before abandoning an access (8-bit counter).
REQ-002 SHALL have ports clk_sys  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have ports reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have cpu_cs, cpu_oe, cpu_we  in  1 each  Oric RAM select, read and write levels.
REQ-005 SHALL have cpu_ad  in  16  CPU byte address; cpu_d  in  8  write data; cpu_q  out  8  read data.
REQ-006 SHALL have dma_wr  in  1  one-cycle write strobe; dma_ad  in  16; dma_d  in  8; dma_busy  out  1  holding register full.
REQ-007 SHALL have sd_req  out  1  toggle request; sd_ack  in  1  toggle acknowledge; sd_we  out  1; sd_ds  out  2  byte enables.
REQ-008 SHALL have sd_a  out  16; sd_d  out  16; sd_q  in  16; err  out  1  sticky timeout flag.

Function
REQ-009 SHALL detect a CPU request on: rising cs&oe, rising cs&we, or cs&oe with cpu_ad differing from the previous cycle.
REQ-010 SHALL latch a detected CPU request (address, data, we) into a one-entry CPU pending slot; a newer detection overwrites it.
REQ-011 SHALL latch dma_wr into a one-entry DMA slot and assert dma_busy on the next edge; dma_wr while dma_busy is dropped.
REQ-012 SHALL implement states IDLE, CPU_WAIT, DMA_WAIT.
REQ-013 SHALL, in IDLE with sd_ack==sd_req, issue the CPU slot if full, else the DMA slot if full; CPU always wins a same-cycle tie.
REQ-014 SHALL on issue toggle sd_req, drive sd_a, sd_we, sd_d={data,data}, and sd_ds=(we ? (a[0] ? 2'b10 : 2'b01) : 2'b11), all on the same edge, clearing the issued slot.
REQ-015 SHALL hold sd_a/sd_we/sd_d/sd_ds stable until completion.
REQ-016 SHALL treat sd_ack==sd_req in CPU_WAIT/DMA_WAIT as completion and return to IDLE on that edge; minimum issue-to-next-issue spacing is 2 cycles.
REQ-017 SHALL on CPU read completion load cpu_q with sd_q[15:8] if a[0]=1 else sd_q[7:0]; cpu_q SHALL otherwise hold.
REQ-018 SHALL clear dma_busy on the DMA completion edge; a new dma_wr in that same cycle is accepted.
REQ-019 SHALL not issue any request while sd_ack!=sd_req in IDLE (post-reset resynchronisation).
REQ-020 SHALL count wait cycles in CPU_WAIT/DMA_WAIT; on reaching TIMEOUT (see REQ-026) return to IDLE, set err, and set sd_req to sd_ack.
REQ-021 SHALL give CPU requests arriving during DMA_WAIT service immediately after DMA completion (CPU latency ≤ one DMA access + 2 cycles).

Reset
REQ-022 SHALL asynchronously on reset_n=0 force state IDLE, sd_req=0, both slots empty, dma_busy=0, err=0, cpu_q=8'h00, sd_a=0, sd_d=0, sd_ds=2'b11, sd_we=0.
REQ-023 SHALL on reset mid-access discard the in-flight access without retry.
REQ-024 SHALL not detect a CPU request in the first cycle after reset release (previous-level registers reset to 0 and address history reset to cpu_ad-independent 0; rising edges after that cycle count).
REQ-025 SHALL clear err only by reset.

Configuration
REQ-026 SHALL compile the timeout counter and err logic only when SDRAM_ARB_TIMEOUT_EN is defined; without it wait states wait indefinitely, err is tied 0, TIMEOUT is ignored.

Verification
REQ-027 SHALL cover: CPU read a=16'h1235, sd_q=16'hAB12, ack 3 cycles later -> sd_ds=2'b11, cpu_q=8'hAB after ack edge.
REQ-028 SHALL cover: CPU write a=16'h0400 d=8'h5A -> sd_we=1, sd_ds=2'b01, sd_d=16'h5A5A, one sd_req toggle.
REQ-029 SHALL cover: CPU oe rise and dma_wr same cycle -> CPU issued first, DMA issued at the edge after CPU ack, dma_busy high throughout.
REQ-030 SHALL cover: two dma_wr 1 cycle apart while busy -> second dropped, exactly one DMA toggle.
REQ-031 SHALL cover: with SDRAM_ARB_TIMEOUT_EN, TIMEOUT=8, ack never returns -> IDLE after 8 wait cycles, err=1, sd_req==sd_ack.
REQ-032 SHALL cover: reset_n low during CPU_WAIT -> all outputs per REQ-022 immediately, no request until sd_ack==sd_req.
